// File: rtl/scroll_char_buffer_if.sv
// Host write / video fetch / command bus of the scrolling character buffer.
// The master drives writes, reads and commands; the buffer is the slave.
interface scroll_char_buffer_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_WIDTH  = 6
);
    logic                  i_wr_en;
    logic [ADDR_WIDTH-1:0] i_wr_adr;
    logic [DATA_WIDTH-1:0] i_data;
    logic [ADDR_WIDTH-1:0] i_rd_adr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_clear;
    logic                  i_scroll;
    logic                  o_busy;
    logic                  o_wr_drop;
    logic [ROW_WIDTH-1:0]  o_scroll_row;

    modport master (
        output i_wr_en, i_wr_adr, i_data, i_rd_adr, i_clear, i_scroll,
        input  o_data, o_busy, o_wr_drop, o_scroll_row
    );

    modport slave (
        input  i_wr_en, i_wr_adr, i_data, i_rd_adr, i_clear, i_scroll,
        output o_data, o_busy, o_wr_drop, o_scroll_row
    );
endinterface

// File: rtl/scroll_char_buffer.sv
// Text-mode char/attr buffer with rotating row base for hardware scroll and a
// one-entry-per-clock fill engine for full clears and newly exposed rows.
module scroll_char_buffer #(
    parameter int                                 COLS       = 80,
    parameter int                                 ROWS       = 60,
    parameter int                                 CHAR_WIDTH = 8,
    parameter int                                 ATTR_WIDTH = 8,
    parameter int                                 ADDR_WIDTH = 13,
    parameter logic [CHAR_WIDTH+ATTR_WIDTH-1:0]   FILL       = 16'h0720,
    parameter string                              INIT_FILE  = ""
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst_n,
    scroll_char_buffer_if.slave  bus
);
    localparam int DEPTH      = COLS * ROWS;
    localparam int DATA_WIDTH = CHAR_WIDTH + ATTR_WIDTH;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] COLS_LAST  = ADDR_WIDTH'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_LAST  = ADDR_WIDTH'(DEPTH - COLS);
    localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(ROWS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLR_ALL = 2'd1;
    localparam logic [1:0] ST_CLR_ROW = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wadr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_phys, rd_phys;

    // Logical-to-physical rotation; the sum gets one extra bit so it cannot overflow.
    function automatic logic [ADDR_WIDTH-1:0] map_adr(input logic [ADDR_WIDTH-1:0] l,
                                                      input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, l} + {1'b0, b};
        if (s >= DEPTH_X) s = s - DEPTH_X;
        return s[ADDR_WIDTH-1:0];
    endfunction

    always_comb begin
        wr_ok     = ({1'b0, bus.i_wr_adr} < DEPTH_X);
        rd_ok     = ({1'b0, bus.i_rd_adr} < DEPTH_X);
        wr_phys   = map_adr(bus.i_wr_adr, base_q);
        rd_phys   = map_adr(bus.i_rd_adr, base_q);
        rd_data_d = rd_ok ? mem[rd_phys] : '0;
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_wadr  = wr_phys;
        mem_wdata = bus.i_data;
        unique case (state_q)
            ST_IDLE: begin
                // A host write in the command cycle still uses the old base.
                mem_we = bus.i_wr_en && wr_ok;
                if (bus.i_clear) begin
                    base_d  = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CLR_ALL;
                end else if (bus.i_scroll) begin
                    clr_ptr_d = base_q;
                    base_d    = (base_q == BASE_LAST) ? '0 : base_q + COLS_A;
                    row_d     = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    cnt_d     = '0;
                    state_d   = ST_CLR_ROW;
                end
            end
            ST_CLR_ALL: begin
                mem_we    = 1'b1;
                mem_wadr  = cnt_q;
                mem_wdata = FILL;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == DEPTH_LAST) state_d = ST_IDLE;
            end
            ST_CLR_ROW: begin
                // Rows start on a COLS boundary, so a row never wraps past DEPTH.
                mem_we    = 1'b1;
                mem_wadr  = clr_ptr_q + cnt_q;
                mem_wdata = FILL;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == COLS_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        drop_d = bus.i_wr_en && wr_ok && (state_q != ST_IDLE);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is deliberately outside reset; nonblocking update gives read-first.
    always_ff @(posedge i_sys_clk) begin
        if (mem_we) mem[mem_wadr] <= mem_wdata;
    end

    assign bus.o_data       = rd_data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_wr_drop    = drop_q;
    assign bus.o_scroll_row = row_q;
endmodule

// File: tb/tb_scroll_char_buffer.sv
// Directed + random bench for scroll_char_buffer against a plain-array screen model.
module tb_scroll_char_buffer;
    localparam int COLS = 80, ROWS = 60, DEPTH = COLS * ROWS;
    localparam int AW = 13, DW = 16, RW = 6;
    localparam logic [15:0] FILL = 16'h0720;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scroll_char_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_WIDTH(RW)) bus ();

    scroll_char_buffer #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_WIDTH(8), .ATTR_WIDTH(8),
        .ADDR_WIDTH(AW), .FILL(FILL), .INIT_FILE("")
    ) dut (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    // Screen model: physical storage plus current top row.
    logic [15:0] mem_m [DEPTH];
    int row_m;
    int total = 0;
    int bad = 0;

    function automatic int phys(input int l);
        return (l + row_m * COLS) % DEPTH;
    endfunction

    function automatic logic [15:0] model_rd(input int l);
        return (l < DEPTH) ? mem_m[phys(l)] : 16'h0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = FILL;
        row_m = 0;
    endtask

    task automatic model_scroll();
        int top;
        top = row_m * COLS;
        for (int i = 0; i < COLS; i++) mem_m[top + i] = FILL;
        row_m = (row_m + 1) % ROWS;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int adr, input logic [15:0] d);
        bus.i_wr_en  = 1'b1;
        bus.i_wr_adr = AW'(adr);
        bus.i_data   = d;
        if (adr < DEPTH) mem_m[phys(adr)] = d;
        tick();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic read_chk(input int adr, input string tag);
        logic [15:0] e;
        e = model_rd(adr);
        bus.i_rd_adr = AW'(adr);
        tick();
        chk(tag, 32'(bus.o_data), 32'(e));
    endtask

    // Issue a command and count the cycles o_busy stays high.
    task automatic run_cmd(input bit clr, input bit scr, output int n);
        bus.i_clear  = clr;
        bus.i_scroll = scr;
        tick();
        bus.i_clear  = 1'b0;
        bus.i_scroll = 1'b0;
        if (clr) model_clear();
        else if (scr) model_scroll();
        n = 0;
        while (bus.o_busy && n < DEPTH + 16) begin
            tick();
            n++;
        end
    endtask

    task automatic random_phase(input int cycles, input string tag);
        int wa, ra;
        logic [15:0] e;
        for (int c = 0; c < cycles; c++) begin
            wa = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 8191 - DEPTH)
                                              : $urandom_range(0, DEPTH - 1);
            ra = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 8191 - DEPTH)
                                              : $urandom_range(0, DEPTH - 1);
            bus.i_wr_en  = $urandom_range(0, 1) == 1;
            bus.i_wr_adr = AW'(wa);
            bus.i_data   = 16'($urandom);
            bus.i_rd_adr = AW'(ra);
            e = model_rd(ra);
            if (bus.i_wr_en && wa < DEPTH) mem_m[phys(wa)] = bus.i_data;
            tick();
            chk(tag, 32'(bus.o_data), 32'(e));
            chk("rand_nodrop", 32'(bus.o_wr_drop), 32'd0);
        end
        bus.i_wr_en = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] d;
        row_m = 0;
        bus.i_wr_en = 1'b0; bus.i_wr_adr = '0; bus.i_data = '0;
        bus.i_rd_adr = '0; bus.i_clear = 1'b0; bus.i_scroll = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_data", 32'(bus.o_data), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_drop", 32'(bus.o_wr_drop), 32'd0);
        chk("rst_row", 32'(bus.o_scroll_row), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write/readback and out-of-range accesses
        host_write(5, 16'h1F41);
        bus.i_rd_adr = AW'(5);
        tick();
        chk("rdback5", 32'(bus.o_data), 32'h1F41);
        read_chk(4800, "rd_oor");
        chk("rd_oor_zero", 32'(bus.o_data), 32'd0);
        host_write(5000, 16'hDEAD);
        chk("wr_oor_nodrop", 32'(bus.o_wr_drop), 32'd0);
        tick();
        chk("wr_oor_nodrop2", 32'(bus.o_wr_drop), 32'd0);
        read_chk(5, "rd5_after_oor");

        // Full clear with a host write rejected mid-way
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        model_clear();
        chk("clr_busy_rise", 32'(bus.o_busy), 32'd1);
        n = 0;
        while (bus.o_busy && n < DEPTH + 16) begin
            if (n == 10) begin
                bus.i_wr_en = 1'b1; bus.i_wr_adr = AW'(7); bus.i_data = 16'hBEEF;
            end
            tick();
            n++;
            if (n == 11) begin
                chk("busy_drop", 32'(bus.o_wr_drop), 32'd1);
                bus.i_wr_en = 1'b0;
            end
            if (n == 12) chk("busy_drop_once", 32'(bus.o_wr_drop), 32'd0);
        end
        chk("clr_busy_len", 32'(n), 32'(DEPTH));
        chk("clr_row", 32'(bus.o_scroll_row), 32'd0);
        for (int a = 0; a < DEPTH; a++) read_chk(a, "clr_fill");
        read_chk(7, "drop_absent");
        chk("drop_absent_fill", 32'(bus.o_data), 32'(FILL));

        random_phase(400, "rand_row0");

        // Single scroll
        host_write(80, 16'h0741);
        run_cmd(1'b0, 1'b1, n);
        chk("scr_busy_len", 32'(n), 32'(COLS));
        chk("scr_row1", 32'(bus.o_scroll_row), 32'd1);
        read_chk(0, "scr_l0");
        chk("scr_l0_A", 32'(bus.o_data), 32'h0741);
        for (int a = DEPTH - COLS; a < DEPTH; a++) read_chk(a, "scr_newrow");
        chk("scr_lastrow_fill", 32'(bus.o_data), 32'(FILL));

        random_phase(300, "rand_row1");

        // Sixty scrolls return to base 0
        run_cmd(1'b1, 1'b0, n);
        for (int s = 0; s < ROWS; s++) begin
            run_cmd(1'b0, 1'b1, n);
            chk("wrap_busy_len", 32'(n), 32'(COLS));
            chk("wrap_row", 32'(bus.o_scroll_row), 32'((s + 1) % ROWS));
        end
        chk("wrap_row0", 32'(bus.o_scroll_row), 32'd0);
        host_write(0, 16'hA1A1);
        host_write(80, 16'hB2B2);
        run_cmd(1'b0, 1'b1, n);
        read_chk(0, "wrap_map");
        chk("wrap_map_pat", 32'(bus.o_data), 32'hB2B2);
        read_chk(DEPTH - COLS, "wrap_top_cleared");
        chk("wrap_top_fill", 32'(bus.o_data), 32'(FILL));

        // Clear and scroll together: clear wins
        run_cmd(1'b1, 1'b1, n);
        chk("both_busy_len", 32'(n), 32'(DEPTH));
        chk("both_row0", 32'(bus.o_scroll_row), 32'd0);
        read_chk(0, "both_l0");
        read_chk(DEPTH - 1, "both_llast");

        // Write to logical 0 in the scroll cycle, then row clear overwrites it
        bus.i_wr_en = 1'b1; bus.i_wr_adr = AW'(0); bus.i_data = 16'h5A5A;
        bus.i_scroll = 1'b1; bus.i_rd_adr = AW'(DEPTH - COLS);
        tick();
        bus.i_wr_en = 1'b0; bus.i_scroll = 1'b0;
        chk("ws_busy", 32'(bus.o_busy), 32'd1);
        tick();
        chk("ws_landed", 32'(bus.o_data), 32'h5A5A);
        mem_m[0] = 16'h5A5A;
        model_scroll();
        n = 2;
        while (bus.o_busy && n < COLS + 16) begin
            tick();
            n++;
        end
        chk("ws_busy_len", 32'(n), 32'(COLS + 1));
        read_chk(DEPTH - COLS, "ws_cleared");
        chk("ws_cleared_fill", 32'(bus.o_data), 32'(FILL));

        // Reset 100 entries into a clear
        run_cmd(1'b1, 1'b0, n);
        for (int a = 0; a < 200; a++) begin
            d = 16'h8000 | 16'($urandom);
            host_write(a, d);
        end
        bus.i_rd_adr = AW'(150);
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        repeat (100) tick();
        chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
        chk("pre_rst_data", 32'(bus.o_data), 32'(mem_m[150]));
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(bus.o_data), 32'd0);
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_row", 32'(bus.o_scroll_row), 32'd0);
        for (int i = 0; i < 100; i++) mem_m[i] = FILL;
        row_m = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 200; a++) read_chk(a, "abort_mem");
        random_phase(200, "rand_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
